// File: rtl/div_sequencer.sv
// Iterative 32-bit restoring divider for the MDU: one quotient bit per cycle,
// same-cycle results for divide-by-zero/overflow. Optional result cache: DIV_RESULT_CACHE_EN.
// state | meaning
// IDLE  | waiting for a divide; special/cached results returned combinationally
// BUSY  | 32 shift-subtract iterations, counter 0..31
// DONE  | latched result presented until the pipeline advances
module div_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [2:0]  MDU_op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        advance_i,
    input  logic        kill_i,
    output logic [31:0] result_o,
    output logic        stall_o,
    output logic        done_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] dq;
    logic [31:0] dvs;
    logic [31:0] rem_p;
    logic [31:0] q_reg;
    logic [31:0] r_reg;
    logic        q_neg;
    logic        r_neg;
    logic        op_rem;
    logic        sel_rem;

    logic        is_signed;
    logic        is_rem;
    logic        start;
    logic        div_zero;
    logic        ovf;
    logic        special;
    logic        hit;
    logic        launch;
    logic [31:0] special_val;
    logic [31:0] hit_val;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] rem_next;
    logic [31:0] q_raw;

`ifdef DIV_RESULT_CACHE_EN
    logic        cache_valid;
    logic [31:0] cache_a;
    logic [31:0] cache_b;
    logic        cache_sgn;
    logic [31:0] pend_a;
    logic [31:0] pend_b;
    logic        pend_sgn;
`endif

    always_comb begin
        is_signed   = ~MDU_op_i[0];
        is_rem      = MDU_op_i[1];
        start       = en_i && MDU_op_i[2] && (state == S_IDLE) && !kill_i;
        div_zero    = (rs2_i == 32'h0);
        ovf         = is_signed && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
        special     = start && (div_zero || ovf);
        if (div_zero)
            special_val = is_rem ? rs1_i : 32'hFFFF_FFFF;
        else
            special_val = is_rem ? 32'h0 : 32'h8000_0000;
`ifdef DIV_RESULT_CACHE_EN
        hit     = start && !special && cache_valid && (rs1_i == cache_a)
                  && (rs2_i == cache_b) && (is_signed == cache_sgn);
        hit_val = is_rem ? r_reg : q_reg;
`else
        hit     = 1'b0;
        hit_val = 32'h0;
`endif
        launch  = start && !special && !hit;
        a_abs   = (is_signed && rs1_i[31]) ? -rs1_i : rs1_i;
        b_abs   = (is_signed && rs2_i[31]) ? -rs2_i : rs2_i;

        // Partial remainder is always below the divisor, so diff[32] is the borrow.
        shifted  = {rem_p, dq[31]};
        diff     = shifted - {1'b0, dvs};
        rem_next = diff[32] ? shifted[31:0] : diff[31:0];
        q_raw    = {dq[30:0], ~diff[32]};

        stall_o  = !rst_i && !kill_i && (launch || (state == S_BUSY));
        done_o   = !rst_i && (state == S_DONE);
        if (rst_i)
            result_o = 32'h0;
        else if (special)
            result_o = special_val;
        else if (hit)
            result_o = hit_val;
        else
            result_o = sel_rem ? r_reg : q_reg;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            dq      <= 32'h0;
            dvs     <= 32'h0;
            rem_p   <= 32'h0;
            q_reg   <= 32'h0;
            r_reg   <= 32'h0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            op_rem  <= 1'b0;
            sel_rem <= 1'b0;
`ifdef DIV_RESULT_CACHE_EN
            cache_valid <= 1'b0;
            cache_a     <= 32'h0;
            cache_b     <= 32'h0;
            cache_sgn   <= 1'b0;
            pend_a      <= 32'h0;
            pend_b      <= 32'h0;
            pend_sgn    <= 1'b0;
`endif
        end else if (kill_i) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        dq     <= a_abs;
                        dvs    <= b_abs;
                        rem_p  <= 32'h0;
                        cnt    <= 5'd0;
                        q_neg  <= is_signed && (rs1_i[31] ^ rs2_i[31]);
                        r_neg  <= is_signed && rs1_i[31];
                        op_rem <= is_rem;
`ifdef DIV_RESULT_CACHE_EN
                        pend_a   <= rs1_i;
                        pend_b   <= rs2_i;
                        pend_sgn <= is_signed;
`endif
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    dq    <= q_raw;
                    rem_p <= rem_next;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        q_reg   <= q_neg ? -q_raw : q_raw;
                        r_reg   <= r_neg ? -rem_next : rem_next;
                        sel_rem <= op_rem;
`ifdef DIV_RESULT_CACHE_EN
                        cache_valid <= 1'b1;
                        cache_a     <= pend_a;
                        cache_b     <= pend_b;
                        cache_sgn   <= pend_sgn;
`endif
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (advance_i)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: driver queues hand-computed results,
// a negedge monitor pops and compares whenever a result is presented.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        advance;
    logic        kill;
    logic [31:0] result;
    logic        stall;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        c_valid = 1'b0;
    logic [31:0] c_a = 32'h0;
    logic [31:0] c_b = 32'h0;
    logic        c_sgn = 1'b0;
    logic        done_q = 1'b0;

    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    div_sequencer dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .MDU_op_i(op),
        .rs1_i(rs1), .rs2_i(rs2), .advance_i(advance), .kill_i(kill),
        .result_o(result), .stall_o(stall), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            done_q = 1'b0;
        end else begin
            if ((done && !done_q) || (!done && en && op[2] && !kill && !stall)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h expected none", result);
                end else begin
                    check("result", result, exp_q.pop_front());
                end
            end
            done_q = done;
        end
    end

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        logic sgn;
        logic sp;
        logic hit;
        int   exp_stall;
        int   stalls;
        sgn = !o[0];
        sp  = (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hit = CACHE_EN && c_valid && c_a == a && c_b == b && c_sgn == sgn;
        exp_stall = (sp || hit) ? 0 : 33;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 en = 1'b1; op = o; rs1 = a; rs2 = b;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!stall || stalls > 100) break;
            stalls++;
        end
        check({name, " stall_cycles"}, stalls, exp_stall);
        if (done) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
                check({name, " hold_result"}, result, exp);
                check({name, " hold_done"}, {31'h0, done}, 32'h1);
            end
            @(posedge clk);
            #1 advance = 1'b1;
            @(posedge clk);
            #1 advance = 1'b0; en = 1'b0;
            @(negedge clk);
            check({name, " idle_after_advance"}, {31'h0, done}, 32'h0);
            if (!sp && !hit) begin
                c_valid = 1'b1; c_a = a; c_b = b; c_sgn = sgn;
            end
        end else begin
            @(posedge clk);
            #1 en = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; op = 3'b000; rs1 = 32'h0; rs2 = 32'h0;
        advance = 1'b0; kill = 1'b0;
        #2;
        check("reset result", result, 32'h0);
        check("reset stall", {31'h0, stall}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // non-divide op must not disturb the sequencer
        @(posedge clk);
        #1 en = 1'b1; op = 3'b001; rs1 = 32'd100; rs2 = 32'd7;
        @(negedge clk);
        check("non_div stall", {31'h0, stall}, 32'h0);
        check("non_div done", {31'h0, done}, 32'h0);
        @(posedge clk);
        #1 en = 1'b0;

        run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 0);
        run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 0);
        run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
        run_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 0);
        run_op("div_x_0", DIV, 32'd1234, 32'h0, 32'hFFFF_FFFF, 0);
        run_op("divu_x_0", DIVU, 32'd1234, 32'h0, 32'hFFFF_FFFF, 0);
        run_op("rem_5_0", REM, 32'd5, 32'h0, 32'd5, 0);
        run_op("remu_5_0", REMU, 32'd5, 32'h0, 32'd5, 0);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
        run_op("divu_big", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
        run_op("remu_big", REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 4);

        // kill in BUSY cycle 10
        @(posedge clk);
        #1 en = 1'b1; op = DIVU; rs1 = 32'd1000; rs2 = 32'd3;
        repeat (11) @(posedge clk);
        #1 kill = 1'b1;
        #1 check("kill stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1 kill = 1'b0; en = 1'b0;
        @(negedge clk);
        check("kill idle stall", {31'h0, stall}, 32'h0);
        check("kill idle done", {31'h0, done}, 32'h0);
        run_op("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 0);

        // reset in the middle of BUSY
        @(posedge clk);
        #1 en = 1'b1; op = DIVU; rs1 = 32'd100; rs2 = 32'd7;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst result", result, 32'h0);
        check("midrst stall", {31'h0, stall}, 32'h0);
        check("midrst done", {31'h0, done}, 32'h0);
        en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        c_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst stall", {31'h0, stall}, 32'h0);
            check("post_rst done", {31'h0, done}, 32'h0);
        end
        run_op("divu_100_7_again", DIVU, 32'd100, 32'd7, 32'd14, 0);
        run_op("remu_100_7_again", REMU, 32'd100, 32'd7, 32'd2, 0);

        repeat (2) @(posedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
